prog_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data port of the program memory between the CPU data path and a DMA requester (flash-to-RAM copy engine). Sits between the bus decoder's program-memory select (`program_mem_ren`/`program_mem_wen`) and the `programMemory` data port. It sequences one access at a time, alternates fairly under contention, and returns a per-requester ready pulse. The CPU ready pulse feeds the CPU stall input (`memReady` path).

---
 rtl/prog_mem_arbiter_pkg.sv | 29 ++
 rtl/prog_mem_arbiter_rd_lat_cnt.sv | 29 ++
 rtl/prog_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_prog_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter: state encoding, owner
// constants and the round-robin grant function.
package arb_pkg;

   // Arbiter states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Requester identities as seen on the owner output
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   // Pick the winner of one arbitration round. Under contention the requester
   // that was not granted last time wins, so neither side can starve.
   function automatic logic pick_owner(input logic cpu_req,
                                       input logic dma_req,
                                       input logic last_owner);
      if (cpu_req && dma_req)
         return (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
      else if (dma_req)
         return OWN_DMA;
      else
         return OWN_CPU;
   endfunction

endpackage

// File: rtl/prog_mem_arbiter_rd_lat_cnt.sv
// Read-latency down-counter. Loaded with RD_LAT-1 while the arbiter issues a
// read, decremented in WAIT; 'expired' marks the last WAIT cycle.
module rd_lat_cnt #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic expired
);

   logic [2:0] cnt;

   // Load on issue, count down while waiting for read data
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset)
         cnt <= 3'd0;
      else if (load)
         cnt <= 3'(RD_LAT - 1);
      else if (dec && (cnt != 3'd0))
         cnt <= cnt - 3'd1;
   end

   assign expired = (cnt == 3'd1);

endmodule

// File: rtl/prog_mem_arbiter.sv
// Program-memory data-port arbiter between the CPU data path and the DMA
// flash-to-RAM copy engine. One access at a time, round-robin under
// contention, one-cycle ready pulse per requester.
// Optional feature: define ARB_STALL_CNT_EN to add the 16-bit saturating
// cpu_stall_cnt output (CPU cycles spent waiting on DMA).
module prog_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_ren,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [3:0]        cpu_be,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              dma_ren,
   input  logic              dma_wen,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic [3:0]        dma_be,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ready,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STALL_CNT_EN
   output logic [15:0]       cpu_stall_cnt,
`endif
   output logic              owner
);

   logic [2:0]        state;
   logic              last_owner;
   logic              is_write;
   logic              cpu_req;
   logic              dma_req;
   logic              grant;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_be;
   logic              lat_expired;

   assign cpu_req = cpu_ren | cpu_wen;
   assign dma_req = dma_ren | dma_wen;
   assign grant   = pick_owner(cpu_req, dma_req, last_owner);

   // Route the winning requester's fields; ren+wen together counts as a write
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path can leave it unassigned and infer a latch.
      sel_write = cpu_wen;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      sel_be    = cpu_be;
      if (grant == OWN_DMA) begin
         sel_write = dma_wen;
         sel_addr  = dma_addr;
         sel_wdata = dma_wdata;
         sel_be    = dma_be;
      end
   end

   rd_lat_cnt #(
      .RD_LAT (RD_LAT)
   ) u_rd_lat_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (state == ST_ISSUE),
      .dec     (state == ST_WAIT),
      .expired (lat_expired)
   );

   // Access sequencer: arbitrate, issue one strobe, wait/capture, pulse ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= OWN_CPU;
         last_owner <= OWN_DMA;
         is_write   <= 1'b0;
         mem_ren    <= 1'b0;
         mem_wen    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= 4'h0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
         cpu_ready  <= 1'b0;
         dma_ready  <= 1'b0;
      end else begin
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req || dma_req) begin
                  owner      <= grant;
                  last_owner <= grant;
                  is_write   <= sel_write;
                  mem_wen    <= sel_write;
                  mem_ren    <= ~sel_write;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_be     <= sel_be;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (is_write) begin
                  cpu_ready <= (owner == OWN_CPU);
                  dma_ready <= (owner == OWN_DMA);
                  state     <= ST_DONE;
               end else if (RD_LAT == 1) begin
                  state <= ST_CAPTURE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (lat_expired)
                  state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (owner == OWN_DMA)
                  dma_rdata <= mem_rdata;
               else
                  cpu_rdata <= mem_rdata;
               cpu_ready <= (owner == OWN_CPU);
               dma_ready <= (owner == OWN_DMA);
               state     <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ARB_STALL_CNT_EN
   logic cpu_stalled;

   // CPU is held off when DMA owns a running access or wins the current round
   assign cpu_stalled = cpu_req &&
                        (((state != ST_IDLE) && (owner == OWN_DMA)) ||
                         ((state == ST_IDLE) && dma_req && (grant == OWN_DMA)));

   // Saturating count of CPU cycles lost to DMA
   always_ff @(posedge clk) begin
      if (reset)
         cpu_stall_cnt <= 16'h0000;
      else if (cpu_stalled && (cpu_stall_cnt != 16'hFFFF))
         cpu_stall_cnt <= cpu_stall_cnt + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter. Instance a uses RD_LAT=1 and is
// the main target; instance b (RD_LAT=2) shares the inputs and is checked only
// in its dedicated read-latency sequence.
module tb_prog_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_ren, cpu_wen, dma_ren, dma_wen;
   logic [29:0] cpu_addr, dma_addr;
   logic [31:0] cpu_wdata, dma_wdata;
   logic [3:0]  cpu_be, dma_be;

   logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_wdata, a_mem_rdata;
   logic        a_cpu_ready, a_dma_ready, a_mem_ren, a_mem_wen, a_owner;
   logic [29:0] a_mem_addr;
   logic [3:0]  a_mem_be;
   logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
   logic        b_cpu_ready, b_dma_ready, b_mem_ren, b_mem_wen, b_owner;
   logic [29:0] b_mem_addr;
   logic [3:0]  b_mem_be;
`ifdef ARB_STALL_CNT_EN
   logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_cpu_rd, exp_dma_rd;

   always #5 clk = ~clk;

   prog_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(1)) dut_a (
      .clk(clk), .reset(reset),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(a_cpu_rdata),
      .cpu_ready(a_cpu_ready),
      .dma_ren(dma_ren), .dma_wen(dma_wen), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_be(dma_be), .dma_rdata(a_dma_rdata),
      .dma_ready(a_dma_ready),
      .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_rdata(a_mem_rdata),
`ifdef ARB_STALL_CNT_EN
      .cpu_stall_cnt(a_stall_cnt),
`endif
      .owner(a_owner)
   );

   prog_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(2)) dut_b (
      .clk(clk), .reset(reset),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(b_cpu_rdata),
      .cpu_ready(b_cpu_ready),
      .dma_ren(dma_ren), .dma_wen(dma_wen), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_be(dma_be), .dma_rdata(b_dma_rdata),
      .dma_ready(b_dma_ready),
      .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
`ifdef ARB_STALL_CNT_EN
      .cpu_stall_cnt(b_stall_cnt),
`endif
      .owner(b_owner)
   );

   // Memory contents: fixed pattern, with one special word at 0x20
   function automatic logic [31:0] mem_fn(input logic [29:0] addr);
      if (addr == 30'h20) return 32'h1234_5678;
      return {addr[15:0], ~addr[15:0]};
   endfunction

   // Read-data model: data valid only RD_LAT cycles after the mem_ren cycle
   logic        a_v0 = 1'b0, b_v0 = 1'b0, b_v1 = 1'b0;
   logic [29:0] a_p0 = '0, b_p0 = '0, b_p1 = '0;
   always @(posedge clk) begin
      a_v0 <= a_mem_ren;
      a_p0 <= a_mem_addr;
      b_v0 <= b_mem_ren;
      b_p0 <= b_mem_addr;
      b_v1 <= b_v0;
      b_p1 <= b_p0;
   end
   assign a_mem_rdata = a_v0 ? mem_fn(a_p0) : 32'hEEEE_EEEE;
   assign b_mem_rdata = b_v1 ? mem_fn(b_p1) : 32'hEEEE_EEEE;

   typedef struct {
      logic        dma;
      logic        ren;
      logic        wen;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          lat;
      logic        exp_wen;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_ren = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 4'h0;
      dma_ren = 0; dma_wen = 0; dma_addr = '0; dma_wdata = '0; dma_be = 4'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_cpu_rd = '0;
      exp_dma_rd = '0;
   endtask

   // One single-requester access on instance a, checked cycle by cycle
   task automatic run_vec(input vec_t v, input string tag);
      logic own_rdy, oth_rdy;
      idle_inputs();
      if (v.dma) begin
         dma_ren = v.ren; dma_wen = v.wen; dma_addr = v.addr;
         dma_wdata = v.wdata; dma_be = v.be;
      end else begin
         cpu_ren = v.ren; cpu_wen = v.wen; cpu_addr = v.addr;
         cpu_wdata = v.wdata; cpu_be = v.be;
      end
      for (int c = 1; c <= v.lat; c++) begin
         tick();
         own_rdy = v.dma ? a_dma_ready : a_cpu_ready;
         oth_rdy = v.dma ? a_cpu_ready : a_dma_ready;
         if (c == 1) begin
            check({tag, " mem_wen"}, a_mem_wen, v.exp_wen);
            check({tag, " mem_ren"}, a_mem_ren, !v.exp_wen);
            check({tag, " mem_addr"}, a_mem_addr, v.addr);
            check({tag, " owner"}, a_owner, v.dma);
            if (v.exp_wen) begin
               check({tag, " mem_wdata"}, a_mem_wdata, v.wdata);
               check({tag, " mem_be"}, a_mem_be, v.be);
            end
         end else begin
            check({tag, " strobes idle"}, {a_mem_ren, a_mem_wen}, 2'b00);
         end
         check({tag, " own ready"}, own_rdy, (c == v.lat));
         check({tag, " other ready"}, oth_rdy, 1'b0);
      end
      if (!v.exp_wen) begin
         if (v.dma) exp_dma_rd = v.exp_rdata;
         else       exp_cpu_rd = v.exp_rdata;
      end
      check({tag, " cpu_rdata"}, a_cpu_rdata, exp_cpu_rd);
      check({tag, " dma_rdata"}, a_dma_rdata, exp_dma_rd);
      idle_inputs();
      tick();
   endtask

   initial begin
      vecs[0] = '{dma:1'b0, ren:1'b0, wen:1'b1, addr:30'h10,   wdata:32'hDEAD_BEEF, be:4'hF, lat:2, exp_wen:1'b1, exp_rdata:32'h0};
      vecs[1] = '{dma:1'b1, ren:1'b0, wen:1'b1, addr:30'h3FF,  wdata:32'hCAFE_F00D, be:4'h3, lat:2, exp_wen:1'b1, exp_rdata:32'h0};
      vecs[2] = '{dma:1'b0, ren:1'b1, wen:1'b0, addr:30'h1234, wdata:32'h0,         be:4'hF, lat:3, exp_wen:1'b0, exp_rdata:32'h1234_EDCB};
      vecs[3] = '{dma:1'b1, ren:1'b1, wen:1'b0, addr:30'h20,   wdata:32'h0,         be:4'hF, lat:3, exp_wen:1'b0, exp_rdata:32'h1234_5678};
      vecs[4] = '{dma:1'b0, ren:1'b1, wen:1'b1, addr:30'h55,   wdata:32'h0102_0304, be:4'hA, lat:2, exp_wen:1'b1, exp_rdata:32'h0};
      vecs[5] = '{dma:1'b1, ren:1'b1, wen:1'b0, addr:30'h3FF,  wdata:32'h0,         be:4'hF, lat:3, exp_wen:1'b0, exp_rdata:32'h03FF_FC00};

      // Reset then idle: everything quiet
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      check("rst strobes", {a_mem_ren, a_mem_wen, a_cpu_ready, a_dma_ready}, 4'h0);
      check("rst mem_addr", a_mem_addr, 30'h0);
      check("rst mem_wdata", a_mem_wdata, 32'h0);
      check("rst mem_be", a_mem_be, 4'h0);
      check("rst cpu_rdata", a_cpu_rdata, 32'h0);
      check("rst dma_rdata", a_dma_rdata, 32'h0);
      check("rst owner", a_owner, 1'b0);
      check("rst owner b", b_owner, 1'b0);
`ifdef ARB_STALL_CNT_EN
      check("rst stall_cnt", a_stall_cnt, 16'h0);
`endif

      // Single-requester table
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // DMA read at RD_LAT=2 on instance b: mem_ren c1, ready+data c4
      do_reset();
      dma_ren = 1'b1; dma_addr = 30'h20;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check($sformatf("lat2 mem_ren c%0d", c), b_mem_ren, (c == 1));
         check($sformatf("lat2 dma_ready c%0d", c), b_dma_ready, (c == 4));
         check($sformatf("lat2 cpu_ready c%0d", c), b_cpu_ready, 1'b0);
         if (c == 3) check("lat2 dma_rdata early", b_dma_rdata, 32'h0);
      end
      check("lat2 dma_rdata", b_dma_rdata, 32'h1234_5678);
      check("lat2 cpu_rdata", b_cpu_rdata, 32'h0);
      idle_inputs();
      tick();

      // Conflict after reset: CPU first, DMA issued c5, ready c7
      do_reset();
      cpu_ren = 1'b1; cpu_addr = 30'h100;
      dma_ren = 1'b1; dma_addr = 30'h200;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("conf1 mem_ren c%0d", c), a_mem_ren, (c == 1 || c == 5));
         check($sformatf("conf1 cpu_ready c%0d", c), a_cpu_ready, (c == 3));
         check($sformatf("conf1 dma_ready c%0d", c), a_dma_ready, (c == 7));
         if (c == 1) check("conf1 addr cpu", a_mem_addr, 30'h100);
         if (c == 5) check("conf1 addr dma", a_mem_addr, 30'h200);
         if (c == 5) check("conf1 owner dma", a_owner, 1'b1);
         if (c == 3) begin
            check("conf1 cpu_rdata", a_cpu_rdata, 32'h0100_FEFF);
            cpu_ren = 1'b0;
         end
      end
      check("conf1 dma_rdata", a_dma_rdata, 32'h0200_FDFF);
      check("conf1 cpu_rdata hold", a_cpu_rdata, 32'h0100_FEFF);
      exp_cpu_rd = 32'h0100_FEFF;
      exp_dma_rd = 32'h0200_FDFF;
      idle_inputs();
      tick();

      // A CPU-only write makes CPU the last owner; next conflict goes to DMA
      run_vec(vecs[0], "cpu_wr");
      cpu_ren = 1'b1; cpu_addr = 30'h300;
      dma_ren = 1'b1; dma_addr = 30'h400;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("conf2 mem_ren c%0d", c), a_mem_ren, (c == 1 || c == 5));
         check($sformatf("conf2 dma_ready c%0d", c), a_dma_ready, (c == 3));
         check($sformatf("conf2 cpu_ready c%0d", c), a_cpu_ready, (c == 7));
         if (c == 1) check("conf2 addr dma", a_mem_addr, 30'h400);
         if (c == 5) check("conf2 addr cpu", a_mem_addr, 30'h300);
         if (c == 3) dma_ren = 1'b0;
      end
      check("conf2 dma_rdata", a_dma_rdata, 32'h0400_FBFF);
      check("conf2 cpu_rdata", a_cpu_rdata, 32'h0300_FCFF);
      exp_cpu_rd = 32'h0300_FCFF;
      exp_dma_rd = 32'h0400_FBFF;
      idle_inputs();
      tick();

      // Reset in the cycle after mem_ren of a CPU read: access abandoned
      cpu_ren = 1'b1; cpu_addr = 30'h44;
      tick();
      check("rstmid mem_ren", a_mem_ren, 1'b1);
      tick();
      check("rstmid ready c2", a_cpu_ready, 1'b0);
      reset = 1'b1;
      cpu_ren = 1'b0;
      tick();
      reset = 1'b0;
      exp_cpu_rd = '0;
      exp_dma_rd = '0;
      check("rstmid ready c3", a_cpu_ready, 1'b0);
      check("rstmid cpu_rdata", a_cpu_rdata, 32'h0);
      check("rstmid strobes", {a_mem_ren, a_mem_wen}, 2'b00);
      tick();
      check("rstmid ready c4", a_cpu_ready, 1'b0);
      run_vec(vecs[2], "rstmid new");

`ifdef ARB_STALL_CNT_EN
      // CPU waits behind a DMA read: three stalled cycles before its grant
      do_reset();
      dma_ren = 1'b1; dma_addr = 30'h8;
      tick();
      cpu_ren = 1'b1; cpu_addr = 30'hC;
      tick();
      tick();
      check("stall dma_ready", a_dma_ready, 1'b1);
      dma_ren = 1'b0;
      tick();
      check("stall cnt at grant", a_stall_cnt, 16'd3);
      tick();
      check("stall cpu issue", {a_mem_ren, a_owner}, 2'b10);
      check("stall cnt after", a_stall_cnt, 16'd3);
      tick();
      tick();
      check("stall cpu_ready", a_cpu_ready, 1'b1);
      idle_inputs();
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
